// File: rtl/frq_div_pkg.sv
// ============================================================================
// Module   : frq_div_pkg
// Brief    : Shared constants and helpers for the programmable divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frq_div_pkg;

  localparam int   DEF_DIV     = 10;
  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // Length of the high phase in square mode: ceil(n/2).
  function automatic logic [31:0] half_up(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/frq_div_ch.sv
// ============================================================================
// Module   : frq_div_ch
// Brief    : One divider channel: counter, shadow/active divisor, output reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frq_div_ch
  import frq_div_pkg::*;
#(
  parameter int CW      = 16,
  parameter int DEF_DIV = frq_div_pkg::DEF_DIV
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          sclr,
  input  logic          en,
  input  logic          mode,
  input  logic          wr,
  input  logic [CW-1:0] wval,
  output logic          div_out
);

  localparam logic [CW-1:0] c_one = CW'(1);
  localparam logic [CW-1:0] c_def = CW'(DEF_DIV);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_act;
  logic [CW-1:0] r_shd;
  logic          r_pend;
  logic          r_out;

  logic [CW-1:0] w_shd;
  logic          w_pend;
  logic          w_act_zero;
  logic          w_wrap;
  logic          w_load;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] w_half;
  logic [CW-1:0] w_cnt_d;
  logic          w_out_d;

  // A write landing on the same edge as a wrap is folded in here so it
  // activates at that very wrap.
  assign w_shd      = wr ? wval : r_shd;
  assign w_pend     = wr | r_pend;
  assign w_act_zero = (r_act == '0);

  // ">=" rather than "==" so a divisor shrunk while paused below the held
  // count wraps on the next enabled edge instead of running through 2^CW.
  assign w_wrap     = en && !w_act_zero && (r_cnt >= (r_act - c_one));
  assign w_load     = w_pend && (sclr || w_wrap || !en || w_act_zero);
  assign w_nxt_cnt  = w_wrap ? '0 : (r_cnt + c_one);
  assign w_half     = CW'(half_up(32'(r_act)));

  always_comb begin
    w_cnt_d = r_cnt;
    w_out_d = r_out;
    if (sclr || w_act_zero) begin
      w_cnt_d = '0;
      w_out_d = 1'b0;
    end else if (en) begin
      w_cnt_d = w_nxt_cnt;
      w_out_d = (mode == MODE_SQUARE) ? (w_nxt_cnt < w_half) : w_wrap;
    end else begin
      w_cnt_d = r_cnt;
      w_out_d = (mode == MODE_SQUARE) ? r_out : 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_act  <= c_def;
      r_shd  <= c_def;
      r_pend <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_out <= w_out_d;
      r_shd <= w_shd;
      if (w_load) begin
        r_act  <= w_shd;
        r_pend <= 1'b0;
      end else begin
        r_pend <= w_pend;
      end
    end
  end

  assign div_out = r_out;

endmodule

`default_nettype wire

// File: rtl/frq_div_prog.sv
// ============================================================================
// Module   : frq_div_prog
// Brief    : CH-channel programmable clock divider with pulse/square outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frq_div_prog
  import frq_div_pkg::*;
#(
  parameter  int CH      = 4,
  parameter  int CW      = 16,
  parameter  int DEF_DIV = frq_div_pkg::DEF_DIV,
  localparam int SW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          sclr,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] mode,
  input  logic          div_we,
  input  logic [SW-1:0] div_sel,
  input  logic [CW-1:0] div_val,
  output logic [CH-1:0] div_out
);

  logic          w_sel_ok;
  logic [CH-1:0] w_we;

  // Addresses past the last channel are dropped (possible when CH is not a
  // power of two).
  assign w_sel_ok = (int'(div_sel) < CH);

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      assign w_we[i] = div_we && w_sel_ok && (int'(div_sel) == i);

      frq_div_ch #(
        .CW      (CW),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .mclk    (mclk),
        .rst     (rst),
        .sclr    (sclr),
        .en      (en[i]),
        .mode    (mode[i]),
        .wr      (w_we[i]),
        .wval    (div_val),
        .div_out (div_out[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_frq_div_prog.sv
// ============================================================================
// Module   : tb_frq_div_prog
// Brief    : Directed scoreboard bench for frq_div_prog (5 channels).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frq_div_prog;

  localparam int CH = 5;
  localparam int CW = 16;
  localparam int SW = 3;

  logic          mclk = 1'b0;
  logic          rst;
  logic          sclr;
  logic [CH-1:0] en;
  logic [CH-1:0] mode;
  logic          div_we;
  logic [SW-1:0] div_sel;
  logic [CW-1:0] div_val;
  logic [CH-1:0] div_out;

  frq_div_prog #(
    .CH      (CH),
    .CW      (CW),
    .DEF_DIV (10)
  ) dut (
    .mclk    (mclk),
    .rst     (rst),
    .sclr    (sclr),
    .en      (en),
    .mode    (mode),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .div_out (div_out)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    string tag;
    int    ch;
    logic  val;
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic push(input string tag, input int ch, input logic v);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      ntot++;
      assert (div_out[e.ch] === e.val) npass++;
      else $error("FAIL %s ch%0d: observed %b expected %b", e.tag, e.ch, div_out[e.ch], e.val);
    end
  endtask

  task automatic cyc();
    @(posedge mclk);
    #1;
    drain();
  endtask

  task automatic wr(input int sel, input int val);
    div_we  = 1'b1;
    div_sel = SW'(sel);
    div_val = CW'(val);
    cyc();
    div_we  = 1'b0;
  endtask

  task automatic clr();
    sclr = 1'b1;
    cyc();
    sclr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sclr = 1'b0; en = '1; mode = '0;
    div_we = 1'b0; div_sel = '0; div_val = '0;
    #1;
    for (int c = 0; c < CH; c++) push("reset", c, 1'b0);
    drain();
    repeat (2) @(posedge mclk);
    #1 rst = 1'b0;

    // Default divide-by-10 ticks on every channel.
    for (int k = 1; k <= 30; k++) begin
      for (int c = 0; c < CH; c++) push("def_tick", c, (k % 10) == 0);
      cyc();
    end

    // ch1 square with odd N=7.
    mode[1] = 1'b1;
    wr(1, 7);
    sclr = 1'b1;
    for (int c = 0; c < CH; c++) push("sclr_zero", c, 1'b0);
    cyc();
    sclr = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      push("sq7", 1, (k % 7) < 4);
      push("sq7_ch0", 0, (k % 10) == 0);
      cyc();
    end

    // Glitch-free update: write N=4 to ch0 while its count is 3.
    clr();
    for (int k = 1; k <= 22; k++) begin
      if (k == 4) begin
        div_we = 1'b1; div_sel = 3'd0; div_val = 16'd4;
      end else begin
        div_we = 1'b0;
      end
      push("upd", 0, (k == 10) || (k == 14) || (k == 18) || (k == 22));
      push("upd_ch1", 1, (k % 7) < 4);
      cyc();
    end

    // Enable pause on ch2 with N=5.
    wr(2, 5);
    clr();
    for (int k = 1; k <= 18; k++) begin
      en[2] = !((k >= 3) && (k <= 9));
      push("pause", 2, (k == 12) || (k == 17));
      push("pause_ch0", 0, (k % 4) == 0);
      cyc();
    end

    // Boundaries: N=0, N=1 pulse, N=1 square, out-of-range select.
    mode[2] = 1'b1;
    mode[3] = 1'b1;
    wr(3, 0);
    wr(0, 1);
    wr(2, 1);
    clr();
    for (int k = 1; k <= 24; k++) begin
      if (k == 13) begin
        div_we = 1'b1; div_sel = 3'd5; div_val = 16'd3;
      end else begin
        div_we = 1'b0;
      end
      push("n1_pulse", 0, 1'b1);
      push("sq7_keep", 1, (k % 7) < 4);
      push("n1_square", 2, 1'b1);
      push("n0", 3, 1'b0);
      push("ch4_keep", 4, (k % 10) == 0);
      cyc();
    end

    // Async reset during a square high phase discards a pending write.
    clr();
    push("pre_rst", 1, 1'b1);
    cyc();
    div_we = 1'b1; div_sel = 3'd4; div_val = 16'd3;
    push("pre_rst", 1, 1'b1);
    cyc();
    div_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < CH; c++) push("async_rst", c, 1'b0);
    drain();
    @(posedge mclk);
    #1;
    for (int c = 0; c < CH; c++) push("rst_hold", c, 1'b0);
    drain();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      push("post_rst", 0, (k % 10) == 0);
      push("post_rst", 1, (k % 10) < 5);
      push("post_rst", 2, (k % 10) < 5);
      push("post_rst", 3, (k % 10) < 5);
      push("post_rst", 4, (k % 10) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frq_div_prog.md
# frq_div_prog

Multi-channel programmable frequency divider and the parametrised successor to the fixed divide-by-10 tick generator. Each of `CH` channels divides `mclk` by its own runtime-programmable ratio. Each channel produces either a one-cycle tick or a near-50% square wave, with per-channel enable and a global synchronous phase-align clear. It sits between the board clock and the timing consumers: display scan, debounce, baud and blink logic.

## Interface
Parameters:
- `CH`, 4, number of independent divider channels (1..16).
- `CW`, 16, divisor/counter width in bits.
- `DEF_DIV`, 10, divisor loaded into every channel at reset.

Ports:
- `mclk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sclr`  in  1  synchronous clear of all channel counters and outputs (phase align).
- `en`  in  CH  per-channel count enable.
- `mode`  in  CH  per-channel output mode: 0 = pulse (tick), 1 = square.
- `div_we`  in  1  divisor write strobe, one cycle.
- `div_sel`  in  $clog2(CH) (min 1)  channel addressed by the write.
- `div_val`  in  CW  new divide ratio N.
- `div_out`  out  CH  per-channel divided output, registered.

## Operation
- Per channel state: `cnt[CW]`, active divisor `act[CW]`, shadow divisor `shd[CW]`, pending flag `pend`, output register.
- On `rst`: `cnt`=0, `act`=`shd`=`DEF_DIV`, `pend`=0, `div_out`=0.
- Counting (en=1, act≥1): `cnt` runs 0..act-1. At `cnt`==act-1 the next `cnt` is 0; this is the wrap.
- Pulse mode: `div_out` is high for exactly one cycle per wrap, registered on the wrap edge. Otherwise 0.
- Square mode: `div_out` <= (next_cnt < ceil(act/2)). This gives high for ceil(N/2) cycles and low for floor(N/2). N=1 gives constant 1.
- `act`=0: counter held at 0 and `div_out`=0, regardless of mode or enable.
- en=0: `cnt` holds. Pulse output drives 0. Square output holds its last value. Counting resumes from the held `cnt`.
- Divisor write: `div_we` stores `div_val` into `shd[div_sel]` and sets `pend`. `div_sel`≥CH is ignored.
- Divisor activation: the pending value moves to `act` at the next wrap, or immediately on the next edge if the channel has en=0 or `act`=0. This keeps periods glitch-free.
- A write in the same cycle as a wrap takes effect at that wrap.
- `sclr`: all `cnt`=0 and `div_out`=0. Pending shadows are copied to `act`. Has priority over enable, wrap and write-activation. A coincident `div_we` still updates the shadow.
- Changing `mode` mid-period takes effect on the next edge using the current `cnt`. No counter reset.

## Timing
- Latency: output registered. No combinational path from any input to `div_out`.
- After `rst` release, with en=1, N=10, pulse mode: first tick is high in the cycle after the 10th rising edge, then every 10 cycles. This is identical to the legacy divide-by-10.
- Square mode, N=10, after `rst` or `sclr`:
  - `div_out` rises on the 1st edge.
  - High for 5 cycles, low for 5.
  - Period 10.
- All channels cleared by the same `sclr` edge are phase-aligned thereafter if their N values are equal.
- `rst` asserted mid-period: outputs drop to 0 asynchronously and pending writes are discarded.

## Structure
- Shared package `frq_div_pkg`:
  - `DEF_DIV`.
  - `MODE_PULSE`=0 and `MODE_SQUARE`=1 constants.
  - Function computing ceil(N/2).
- Sub-module `frq_div_ch`:
  - One channel: counter, shadow/active divisor, output logic.
  - Instantiated `CH` times in a generate loop.
- Top level holds write decode and fans out `sclr`/`rst`.

## Test plan
- Reset defaults: `rst` pulse, en=all 1, mode=0 → each `div_out` ticks once every 10 cycles, first tick after the 10th edge.
- Square/odd N: write N=7 to ch1, mode=1, then `sclr` → `div_out[1]` is high 4 cycles, low 3, repeating.
- Glitch-free update: ch0 at N=10, write N=4 at cnt=3 → the current period completes at 10 cycles, then ticks every 4.
- Enable pause: ch2 N=5 pulse, drop en for 7 cycles at cnt=2 → no tick while paused; next tick 3 cycles after en returns.
- Boundaries: N=0 → output stays 0; N=1 pulse → high every cycle; N=1 square → constant 1; `div_sel`=CH → no channel changes.
- Reset mid-operation: assert `rst` asynchronously during a square high phase → `div_out` drops to 0 before the next edge, and `act` returns to 10.
